dv_mem_arbiter: RTL and testbench
=================================

# dv_mem_arbiter

Round-robin arbiter sharing one single-port DV memory model (1-cycle registered read, read port frozen on write cycles) among NREQ requesters in the crypto-accelerator testbench. Each requester gets a valid/ready request channel and a tagged read-response strobe. Locked bursts give one requester exclusive access across several beats. The block sits between the stimulus/engine agents and the memory model; it owns the memory's `we`/`addr`/`din` and consumes its `dout`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `DW`, 16: data width; must match the memory.
- `AW`, 20: address width; must match the memory.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  request accepted this cycle; one-hot or zero.
- `req_we`  in  NREQ  1 = write, 0 = read.
- `req_last`  in  NREQ  final beat of a locked burst; 1 for single accesses.
- `req_addr`  in  NREQ*AW  packed; requester i at [i*AW +: AW].
- `req_wdata`  in  NREQ*DW  packed; requester i at [i*DW +: DW].
- `rsp_valid`  out  NREQ  read data valid for requester i (one-cycle pulse).
- `rsp_rdata`  out  DW  read data, shared by all requesters; meaningful only while some `rsp_valid` bit is high.
- `mem_we`  out  1  to memory `we`.
- `mem_addr`  out  AW  to memory `addr`.
- `mem_din`  out  DW  to memory `din`.
- `mem_dout`  in  DW  from memory `dout`.

## Operation
- State `ARB`:
  - The winner is the first requester with `req_valid` high, searching upward from `ptr` mod NREQ.
  - `req_ready[winner]` is combinational on the same cycle.
  - On accept, `ptr` becomes winner+1 mod NREQ.
  - If the winner's `req_last` = 0, go to `LOCKED` with `owner` = winner. Otherwise stay in `ARB`.
- State `LOCKED`:
  - Only `owner` can be granted; all other requesters see `req_ready` = 0.
  - If the owner's `req_valid` is low, the cycle is idle and the state holds.
  - An accepted owner beat with `req_last` = 1 returns the block to `ARB`.
  - `ptr` does not change while in `LOCKED`.
- Memory drive, all combinational from the granted channel:
  - `mem_we` = granted `req_we`; `mem_addr` and `mem_din` = granted address and data.
  - With no grant: `mem_we` = 0, `mem_addr` = 0, `mem_din` = 0. This idle read of address 0 is permitted.
- Read response:
  - An accepted read sets `rsp_valid[winner]` on the next edge for exactly one cycle.
  - `rsp_rdata` = `mem_dout` (pass-through).
  - Writes never produce a response.
- Reset (any time, including mid-burst):
  - State `ARB`, `ptr` = 0, `owner` = 0, `rsp_valid` = 0.
  - Any in-flight read response is dropped.
  - `req_ready` and `mem_*` follow combinationally from the reset state.

## Timing
- Requester obligations: hold `req_valid`, `req_we`, `req_last`, `req_addr` and `req_wdata` stable until `req_ready`. A request must not be withdrawn once raised.
- Throughput: one access per cycle; back-to-back grants are allowed, including to the same requester.
- Read latency: accept at edge T gives `rsp_valid` and valid `rsp_rdata` in cycle T..T+1.
- A write accepted at edge T is visible to a read accepted at edge T+1.
- Write then read of the same address gives read-after-write ordering; no hazard stalls exist.
- Simultaneous read-response pulse and new accept: both occur independently.
- `rsp_valid` is one-hot or zero.

## Configuration
- Macro `DV_MEM_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority, lowest index wins; `ptr` is held at 0; `LOCKED` behaviour is unchanged.
- Undefined (default): round-robin as described above.

## Test plan
- Reset, then idle: all outputs 0. Read addr 0x00010 from req 1 -> `req_ready` = 0010 the same cycle; `rsp_valid` = 0010 the next cycle with stored data.
- All four requesters hold reads after reset -> grants 0, 1, 2, 3, 0 on consecutive cycles. With `DV_MEM_ARB_FIXED_PRIO_EN` defined -> req 0 every cycle.
- Req 2 writes 0xBEEF to 0x00042, then reads 0x00042 on the next cycle -> `rsp_rdata` = 0xBEEF with `rsp_valid` = 0100.
- Req 1 runs a 3-beat locked burst (`req_last` = 0, 0, 1) while req 0 is valid, with a 2-cycle req 1 gap mid-burst -> req 0 blocked until after beat 3, then granted next.
- Assert `rst_n` low mid-burst, in the cycle after a read accept -> `rsp_valid` = 0 immediately. After release, state is `ARB` and the lowest valid requester wins.

Source files
------------

// File: rtl/dv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port DV memory among NREQ requesters, with locked bursts.
// Define DV_MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module dv_mem_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ-1:0]    req_last,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {StArb, StLocked} state_e;

    state_e           state_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    owner_q;
    logic [NREQ-1:0]  rsp_valid_q;

    logic             gnt_any;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    cand;
    logic [NREQ-1:0]  gnt_vec;

    // Winner selection: owner only while locked, else first valid at or above ptr (wrapping).
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (state_q == StLocked) begin
            gnt_any = req_valid[owner_q];
            gnt_idx = owner_q;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cand = PW'((32'(ptr_q) + i) % NREQ);
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        gnt_vec = '0;
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = gnt_vec;

    // Memory port is driven straight from the granted channel; idle reads address 0.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_vec[i]) begin
                mem_we   = req_we[i];
                mem_addr = req_addr[i*AW +: AW];
                mem_din  = req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StArb;
            ptr_q       <= '0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= (gnt_any && !req_we[gnt_idx]) ? gnt_vec : '0;
            case (state_q)
                StArb: begin
                    if (gnt_any) begin
`ifdef DV_MEM_ARB_FIXED_PRIO_EN
                        ptr_q <= '0;
`else
                        ptr_q <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
`endif
                        if (!req_last[gnt_idx]) begin
                            state_q <= StLocked;
                            owner_q <= gnt_idx;
                        end
                    end
                end
                StLocked: begin
                    if (gnt_any && req_last[gnt_idx]) begin
                        state_q <= StArb;
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = mem_dout;

endmodule

// File: tb/tb_dv_mem_arbiter.sv
// Self-checking bench for dv_mem_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_dv_mem_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int AW   = 20;
`ifdef DV_MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NREQ-1:0]     req_valid, req_ready, req_we, req_last, rsp_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [DW-1:0]       rsp_rdata, mem_din, mem_dout;
    logic [AW-1:0]       mem_addr;
    logic                mem_we;

    logic [NREQ-1:0]     p_valid, p_we, p_last;
    logic [AW-1:0]       p_addr [NREQ];
    logic [DW-1:0]       p_data [NREQ];

    logic [DW-1:0]       mem_store [256];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_ptr;
    int          m_owner;
    int          exp_rsp;
    bit          exp_known;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] m_mem [256];
    bit          m_known [256];

    always #5 clk = ~clk;

    dv_mem_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always_comb begin
        req_valid = p_valid;
        req_we    = p_we;
        req_last  = p_last;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = p_addr[i];
            req_wdata[i*DW +: DW] = p_data[i];
        end
    end

    // Single-port memory: registered read, read port holds on write cycles
    always @(posedge clk) begin
        if (mem_we) mem_store[mem_addr[7:0]] <= mem_din;
        else        mem_dout <= mem_store[mem_addr[7:0]];
    end

    function automatic int model_grant(logic [NREQ-1:0] v);
        if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_commit(int g);
        logic [7:0] a;
        if (g < 0) begin
            exp_rsp = -1;
            return;
        end
        a = p_addr[g][7:0];
        if (p_we[g]) begin
            m_mem[a]   = p_data[g];
            m_known[a] = 1'b1;
            exp_rsp    = -1;
        end else begin
            exp_rsp   = g;
            exp_known = m_known[a];
            exp_data  = m_mem[a];
        end
        if (m_owner < 0) begin
            m_ptr = FIXED ? 0 : (g + 1) % NREQ;
            if (!p_last[g]) m_owner = g;
        end else if (p_last[g]) begin
            m_owner = -1;
        end
    endfunction

    task automatic idle_inputs();
        p_valid = '0;
        p_we    = '0;
        p_last  = '1;
        for (int i = 0; i < NREQ; i++) begin
            p_addr[i] = '0;
            p_data[i] = '0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp got %b want 0000", rsp_valid); end
        n_cmp++; if ({mem_we, mem_addr, mem_din} !== '0) begin n_fail++; $display("FAIL reset_mem got we=%b a=%h d=%h want 0", mem_we, mem_addr, mem_din); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready got %b want 0000", req_ready); end
        n_cmp++; if ({mem_we, mem_addr, mem_din} !== '0) begin n_fail++; $display("FAIL idle_mem got we=%b a=%h d=%h want 0", mem_we, mem_addr, mem_din); end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        p_valid = 4'b0010; p_we = 4'b0010; p_last = 4'b1111;
        p_addr[1] = 20'h00010; p_data[1] = 16'h1234;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL sr_wr_ready got %b want 0010", req_ready); end
        n_cmp++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 20'h00010, 16'h1234}) begin n_fail++; $display("FAIL sr_wr_mem got we=%b a=%h d=%h want 1 00010 1234", mem_we, mem_addr, mem_din); end
        @(negedge clk);
        p_we = 4'b0000;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL sr_rd_ready got %b want 0010", req_ready); end
        n_cmp++; if ({mem_we, mem_addr} !== {1'b0, 20'h00010}) begin n_fail++; $display("FAIL sr_rd_mem got we=%b a=%h want 0 00010", mem_we, mem_addr); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL sr_rsp_valid got %b want 0010", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 16'h1234) begin n_fail++; $display("FAIL sr_rsp_data got %h want 1234", rsp_rdata); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL sr_idle_ready got %b want 0000", req_ready); end
    endtask

    task automatic test_rr_order();
        logic [NREQ-1:0] e, prev;
        apply_reset();
        p_valid = 4'b1111; p_we = 4'b0000; p_last = 4'b1111;
        for (int i = 0; i < NREQ; i++) p_addr[i] = AW'(i + 8'h20);
        prev = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            e = FIXED ? 4'b0001 : (4'b0001 << (k % NREQ));
            n_cmp++; if (req_ready !== e) begin n_fail++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, e); end
            if (k > 0) begin
                n_cmp++; if (rsp_valid !== prev) begin n_fail++; $display("FAIL rr_rsp%0d got %b want %b", k, rsp_valid, prev); end
            end
            prev = e;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_raw();
        @(negedge clk);
        p_valid = 4'b0100; p_we = 4'b0100; p_last = 4'b1111;
        p_addr[2] = 20'h00042; p_data[2] = 16'hBEEF;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL raw_wr_ready got %b want 0100", req_ready); end
        n_cmp++; if ({mem_we, mem_din} !== {1'b1, 16'hBEEF}) begin n_fail++; $display("FAIL raw_wr_mem got we=%b d=%h want 1 beef", mem_we, mem_din); end
        @(negedge clk);
        p_we = 4'b0000;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL raw_rd_ready got %b want 0100", req_ready); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL raw_wr_norsp got %b want 0000", rsp_valid); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL raw_rsp_valid got %b want 0100", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL raw_rsp_data got %h want beef", rsp_rdata); end
    endtask

    task automatic test_locked_burst();
        apply_reset();
        p_valid = 4'b0010; p_we = 4'b0000; p_last = 4'b1101;
        p_addr[1] = 20'h00080; p_addr[0] = 20'h00090;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL lk_beat1 got %b want 0010", req_ready); end
        @(negedge clk);
        p_valid = 4'b0001; p_last = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL lk_gap1 got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL lk_rsp1 got %b want 0010", rsp_valid); end
        @(negedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL lk_gap2 got %b want 0000", req_ready); end
        @(negedge clk);
        p_valid = 4'b0011; p_last = 4'b1101; p_addr[1] = 20'h00081;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL lk_beat2 got %b want 0010", req_ready); end
        @(negedge clk);
        p_last = 4'b1111; p_addr[1] = 20'h00082;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL lk_beat3 got %b want 0010", req_ready); end
        @(negedge clk);
        p_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL lk_after got %b want 0001", req_ready); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        p_valid = 4'b0010; p_we = 4'b0000; p_last = 4'b1101;
        p_addr[1] = 20'h00080; p_addr[0] = 20'h00091;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rm_beat1 got %b want 0010", req_ready); end
        @(negedge clk);
        p_valid = 4'b0011; p_addr[1] = 20'h00081;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rm_rsp_drop got %b want 0000", rsp_valid); end
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_in_reset got %b want 0001", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_after got %b want 0001", req_ready); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rm_after_rsp got %b want 0000", rsp_valid); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        int g;
        logic [NREQ-1:0] e_rdy, e_rsp;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic e_we;
        apply_reset();
        m_ptr = 0; m_owner = -1; exp_rsp = -1; exp_known = 1'b0; exp_data = '0;
        for (int i = 0; i < 256; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = '0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!p_valid[i] && $urandom_range(0, 1) == 1) begin
                    p_valid[i] = 1'b1;
                    p_we[i]    = ($urandom_range(0, 2) == 0);
                    p_last[i]  = ($urandom_range(0, 3) != 0);
                    p_addr[i]  = AW'($urandom_range(0, 15));
                    p_data[i]  = DW'($urandom);
                end
            end
            #1;
            g      = model_grant(p_valid);
            e_rdy  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            e_rsp  = (exp_rsp >= 0) ? (4'b0001 << exp_rsp) : 4'b0000;
            e_we   = (g >= 0) ? p_we[g] : 1'b0;
            e_addr = (g >= 0) ? p_addr[g] : '0;
            e_din  = (g >= 0) ? p_data[g] : '0;
            n_cmp++; if (req_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d got %b want %b", cyc, req_ready, e_rdy); end
            n_cmp++; if ({mem_we, mem_addr, mem_din} !== {e_we, e_addr, e_din}) begin n_fail++; $display("FAIL rnd_mem c%0d got %b %h %h want %b %h %h", cyc, mem_we, mem_addr, mem_din, e_we, e_addr, e_din); end
            n_cmp++; if (rsp_valid !== e_rsp) begin n_fail++; $display("FAIL rnd_rsp c%0d got %b want %b", cyc, rsp_valid, e_rsp); end
            if (exp_rsp >= 0 && exp_known) begin
                n_cmp++; if (rsp_rdata !== exp_data) begin n_fail++; $display("FAIL rnd_rdata c%0d got %h want %h", cyc, rsp_rdata, exp_data); end
            end
            model_commit(g);
            @(negedge clk);
            if (g >= 0) p_valid[g] = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_rr_order();
        test_raw();
        test_locked_burst();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
